// File: rtl/fir_sample_packer.sv
// Packs P_SAMPLES consecutive {ch1,ch0} beats into one wide FIR input word; 1-cycle latency.
// One assembly stage plus one output stage; s_tready drops only while a finished group waits.
module fir_sample_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int P_SAMPLES  = 8
) (
  input  logic                                     clk,
  input  logic                                     nrst,
  input  logic                                     s_tvalid,
  output logic                                     s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]           s_tdata,
  input  logic                                     s_tlast,
  output logic                                     m_tvalid,
  input  logic                                     m_tready,
  output logic [CHANNELS*P_SAMPLES*DATA_WIDTH-1:0] m_tdata,
  output logic                                     m_tlast,
  output logic [$clog2(P_SAMPLES+1)-1:0]           m_tcount
);

  localparam int OW    = CHANNELS * P_SAMPLES * DATA_WIDTH;
  localparam int TW    = $clog2(P_SAMPLES + 1);
  localparam int CNT_W = (P_SAMPLES > 1) ? $clog2(P_SAMPLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OW-1:0]    asm_q, asm_d;
  logic             asm_last_q, asm_last_d;
  logic [TW-1:0]    asm_cnt_q, asm_cnt_d;
  logic             pending_q, pending_d;
  logic             rdy_q, rdy_d;
  logic             out_vld_q, out_vld_d;
  logic [OW-1:0]    out_dat_q, out_dat_d;
  logic             out_last_q, out_last_d;
  logic [TW-1:0]    out_cnt_q, out_cnt_d;

  logic             accept;
  logic             last_lane;
  logic             complete;
  logic             out_free;
  logic             release_pend;
  logic [TW-1:0]    fill_cnt;
  logic [OW-1:0]    asm_merged;

  assign accept       = s_tvalid && rdy_q;
  assign last_lane    = (cnt_q == CNT_W'(P_SAMPLES - 1));
  assign complete     = accept && (last_lane || s_tlast);
  assign out_free     = !out_vld_q || m_tready;
  assign release_pend = pending_q && out_free;
  assign fill_cnt     = TW'(cnt_q) + TW'(1);

  // Assembly contents with the current beat dropped into lane cnt_q of every channel.
  always_comb begin
    asm_merged = asm_q;
    for (int k = 0; k < P_SAMPLES; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        for (int c = 0; c < CHANNELS; c++) begin
          asm_merged[c*P_SAMPLES*DATA_WIDTH + DATA_WIDTH*k +: DATA_WIDTH] =
            s_tdata[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    asm_last_d = asm_last_q;
    asm_cnt_d  = asm_cnt_q;
    pending_d  = pending_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_last_d = out_last_q;
    out_cnt_d  = out_cnt_q;

    if (release_pend) begin
      out_vld_d  = 1'b1;
      out_dat_d  = asm_q;
      out_last_d = asm_last_q;
      out_cnt_d  = asm_cnt_q;
      pending_d  = 1'b0;
      asm_d      = '0;
      asm_last_d = 1'b0;
      asm_cnt_d  = '0;
    end else if (complete) begin
      cnt_d = '0;
      if (out_free) begin
        out_vld_d  = 1'b1;
        out_dat_d  = asm_merged;
        out_last_d = s_tlast;
        out_cnt_d  = fill_cnt;
        asm_d      = '0;
      end else begin
        pending_d  = 1'b1;
        asm_d      = asm_merged;
        asm_last_d = s_tlast;
        asm_cnt_d  = fill_cnt;
      end
    end else begin
      if (accept) begin
        asm_d = asm_merged;
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (out_vld_q && m_tready) begin
        out_vld_d = 1'b0;
      end
    end

    // Ready returns one cycle after a pending group leaves, never on the release edge itself.
    rdy_d = !pending_d && !pending_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q      <= '0;
      asm_q      <= '0;
      asm_last_q <= 1'b0;
      asm_cnt_q  <= '0;
      pending_q  <= 1'b0;
      rdy_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_last_q <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      asm_last_q <= asm_last_d;
      asm_cnt_q  <= asm_cnt_d;
      pending_q  <= pending_d;
      rdy_q      <= rdy_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_last_q <= out_last_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  assign s_tready = rdy_q;
  assign m_tvalid = out_vld_q;
  assign m_tdata  = out_dat_q;
  assign m_tlast  = out_last_q;
  assign m_tcount = out_cnt_q;

endmodule

// File: tb/tb_fir_sample_packer.sv
// Directed bench for fir_sample_packer: packing, early close, backpressure, reset.
module tb_fir_sample_packer;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int P  = 8;
  localparam int OW = CH * P * DW;
  localparam int TW = $clog2(P + 1);

  logic             clk = 1'b0;
  logic             nrst = 1'b1;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [CH*DW-1:0] s_tdata = '0;
  logic             s_tlast = 1'b0;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic [OW-1:0]    m_tdata;
  logic             m_tlast;
  logic [TW-1:0]    m_tcount;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
    logic [TW-1:0] c;
  } wrd_t;
  wrd_t q[$];

  fir_sample_packer #(.DATA_WIDTH(DW), .CHANNELS(CH), .P_SAMPLES(P)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tcount (m_tcount)
  );

  always #5 clk = ~clk;

  // Records every output handshake; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (nrst && m_tvalid && m_tready) begin
      q.push_back('{d: m_tdata, l: m_tlast, c: m_tcount});
    end
  end

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] mk(input logic [15:0] b0, input logic [15:0] b1,
                                        input int n, input logic inc);
    logic [OW-1:0] w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      w[DW*k +: DW]        = inc ? b0 + 16'(k) : b0;
      w[P*DW + DW*k +: DW] = inc ? b1 + 16'(k) : b1;
    end
    return w;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns 1 time unit after the edge that accepted it.
  task automatic beat(input logic [15:0] c0, input logic [15:0] c1, input logic last);
    logic rdy;
    int   n;
    n        = 0;
    s_tvalid = 1'b1;
    s_tdata  = {c1, c0};
    s_tlast  = last;
    do begin
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk);
      #1;
      if (!rdy) stalls++;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) chk("beat_timeout", OW'(rdy), OW'(1));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pop_word(input string tag, input logic [OW-1:0] d, input logic l,
                          input logic [TW-1:0] c);
    wrd_t w;
    chk({tag, "_present"}, OW'(q.size() > 0), OW'(1));
    if (q.size() > 0) begin
      w = q.pop_front();
      chk({tag, "_data"}, w.d, d);
      chk({tag, "_last"}, OW'(w.l), OW'(l));
      chk({tag, "_count"}, OW'(w.c), OW'(c));
    end
  endtask

  task automatic chk_out(input string tag, input logic [OW-1:0] d, input logic l,
                         input logic [TW-1:0] c);
    chk({tag, "_vld"}, OW'(m_tvalid), OW'(1));
    chk({tag, "_data"}, m_tdata, d);
    chk({tag, "_last"}, OW'(m_tlast), OW'(l));
    chk({tag, "_count"}, OW'(m_tcount), OW'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [OW-1:0] wa, wb;

    // Reset state
    #1 nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready", OW'(s_tready), OW'(0));
    chk("rst_m_tvalid", OW'(m_tvalid), OW'(0));
    chk("rst_m_tdata", m_tdata, OW'(0));
    chk("rst_m_tlast", OW'(m_tlast), OW'(0));
    chk("rst_m_tcount", OW'(m_tcount), OW'(0));
    @(negedge clk) nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_s_tready", OW'(s_tready), OW'(1));

    // Full-rate packing
    m_tready = 1'b1;
    stalls   = 0;
    wa = mk(16'h0001, 16'h1001, 8, 1'b1);
    wb = mk(16'h0009, 16'h1009, 8, 1'b1);
    for (int i = 0; i < 16; i++) begin
      beat(16'(i + 1), 16'h1001 + 16'(i), 1'b0);
      if (i == 7) begin
        chk_out("fr_w1", wa, 1'b0, TW'(8));
        chk("fr_lane0_ch0", OW'(m_tdata[15:0]), OW'(16'h0001));
        chk("fr_lane7_ch0", OW'(m_tdata[112 +: 16]), OW'(16'h0008));
        chk("fr_lane0_ch1", OW'(m_tdata[128 +: 16]), OW'(16'h1001));
        chk("fr_lane7_ch1", OW'(m_tdata[240 +: 16]), OW'(16'h1008));
      end
      if (i == 8) chk("fr_drain_vld", OW'(m_tvalid), OW'(0));
      if (i == 15) chk_out("fr_w2", wb, 1'b0, TW'(8));
    end
    cyc(1);
    chk("fr_stalls", OW'(stalls), OW'(0));
    pop_word("fr_q1", wa, 1'b0, TW'(8));
    pop_word("fr_q2", wb, 1'b0, TW'(8));
    chk("fr_qempty", OW'(q.size()), OW'(0));

    // Backpressure with a pending second word
    m_tready = 1'b0;
    wa = mk(16'h0101, 16'h2101, 8, 1'b1);
    wb = mk(16'h0109, 16'h2109, 8, 1'b1);
    for (int i = 0; i < 16; i++) beat(16'h0101 + 16'(i), 16'h2101 + 16'(i), 1'b0);
    chk("bp_rdy_drop", OW'(s_tready), OW'(0));
    chk_out("bp_hold", wa, 1'b0, TW'(8));
    s_tvalid = 1'b1;
    s_tdata  = 32'h0FFF_0FFF;
    cyc(3);
    chk("bp_hold_data", m_tdata, wa);
    chk("bp_rdy_still", OW'(s_tready), OW'(0));
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    cyc(1);
    m_tready = 1'b0;
    chk_out("bp_w2", wb, 1'b0, TW'(8));
    chk("bp_rdy_lag", OW'(s_tready), OW'(0));
    cyc(1);
    chk("bp_rdy_back", OW'(s_tready), OW'(1));
    m_tready = 1'b1;
    cyc(1);
    chk("bp_drain_vld", OW'(m_tvalid), OW'(0));
    pop_word("bp_q1", wa, 1'b0, TW'(8));
    pop_word("bp_q2", wb, 1'b0, TW'(8));
    chk("bp_qempty", OW'(q.size()), OW'(0));

    // Single-beat group; also proves the beat offered while stalled was dropped
    beat(16'h7FFF, 16'h8000, 1'b1);
    chk_out("sb", mk(16'h7FFF, 16'h8000, 1, 1'b0), 1'b1, TW'(1));
    chk("sb_ch0_lane0", OW'(m_tdata[15:0]), OW'(16'h7FFF));
    chk("sb_ch1_lane0", OW'(m_tdata[128 +: 16]), OW'(16'h8000));
    cyc(1);
    pop_word("sb_q", mk(16'h7FFF, 16'h8000, 1, 1'b0), 1'b1, TW'(1));

    // Early close after three beats, then a fresh group from lane 0
    beat(16'hAAAA, 16'hBBBB, 1'b0);
    beat(16'hAAAA, 16'hBBBB, 1'b0);
    beat(16'hAAAA, 16'hBBBB, 1'b1);
    chk_out("ec", mk(16'hAAAA, 16'hBBBB, 3, 1'b0), 1'b1, TW'(3));
    chk("ec_lane3_zero", OW'(m_tdata[48 +: 16]), OW'(0));
    cyc(1);
    pop_word("ec_q", mk(16'hAAAA, 16'hBBBB, 3, 1'b0), 1'b1, TW'(3));
    beat(16'h1111, 16'h2222, 1'b0);
    beat(16'h1112, 16'h2223, 1'b1);
    cyc(1);
    pop_word("ec_next", mk(16'h1111, 16'h2222, 2, 1'b1), 1'b1, TW'(2));

    // Completion on the same edge as the drain of the previous word
    m_tready = 1'b0;
    wa = mk(16'h0301, 16'h4301, 8, 1'b1);
    wb = mk(16'h0309, 16'h4309, 8, 1'b1);
    for (int i = 0; i < 15; i++) beat(16'h0301 + 16'(i), 16'h4301 + 16'(i), 1'b0);
    chk_out("sim_wa_held", wa, 1'b0, TW'(8));
    m_tready = 1'b1;
    beat(16'h0310, 16'h4310, 1'b0);
    chk_out("sim_wb", wb, 1'b0, TW'(8));
    chk("sim_q_one", OW'(q.size()), OW'(1));
    cyc(1);
    pop_word("sim_q1", wa, 1'b0, TW'(8));
    pop_word("sim_q2", wb, 1'b0, TW'(8));
    chk("sim_qempty", OW'(q.size()), OW'(0));

    // Asynchronous reset in the middle of a group
    for (int i = 0; i < 5; i++) beat(16'h0501 + 16'(i), 16'h4501 + 16'(i), 1'b0);
    #2 nrst = 1'b0;
    #1;
    chk("mr_s_tready", OW'(s_tready), OW'(0));
    chk("mr_m_tvalid", OW'(m_tvalid), OW'(0));
    chk("mr_m_tdata", m_tdata, OW'(0));
    chk("mr_m_tlast", OW'(m_tlast), OW'(0));
    chk("mr_m_tcount", OW'(m_tcount), OW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    chk("mr_rdy", OW'(s_tready), OW'(1));
    wa = mk(16'h0601, 16'h4601, 8, 1'b1);
    for (int i = 0; i < 8; i++) beat(16'h0601 + 16'(i), 16'h4601 + 16'(i), 1'b0);
    chk_out("mr_word", wa, 1'b0, TW'(8));
    cyc(1);
    pop_word("mr_q", wa, 1'b0, TW'(8));
    chk("mr_qempty", OW'(q.size()), OW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_sample_packer.md
Name: fir_sample_packer

Overview:
- Upstream feeder for the dual-channel decimating FIR.
- Accepts one sample per channel per beat as {ch1, ch0} on an AXI-stream-style valid/ready input.
- Gathers P_SAMPLES consecutive beats into one wide parallel word in the FIR's s_tdata layout and presents it with valid/ready.
- Absorbs downstream backpressure with one assembly stage plus one output stage, and supports early group close via s_tlast with zero-fill.

Parameters:
- DATA_WIDTH, 16, sample width per channel.
- CHANNELS, 2, number of channels (lane layout is defined for 2).
- P_SAMPLES, 8, beats gathered per output word.

Ports:
- clk  in  1  clock, all logic on rising edge.
- nrst  in  1  asynchronous active-low reset.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input ready; registered.
- s_tdata  in  CHANNELS*DATA_WIDTH  {ch1[15:0], ch0[15:0]}.
- s_tlast  in  1  close current group after this beat.
- m_tvalid  out  1  packed word valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  CHANNELS*P_SAMPLES*DATA_WIDTH  packed word; ch0 lane k at [DATA_WIDTH*k +: DATA_WIDTH], ch1 lane k at [P_SAMPLES*DATA_WIDTH + DATA_WIDTH*k +: DATA_WIDTH].
- m_tlast  out  1  word was closed by s_tlast.
- m_tcount  out  $clog2(P_SAMPLES+1)  number of filled lanes (1..P_SAMPLES).

Behaviour:
- Reset (async assert, sync release):
  - Reset values: s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tcount=0.
  - Internal state reset: lane counter=0, assembly register=0, pending=0.
  - s_tready rises on the first clk edge after nrst deasserts.
- Input acceptance:
  - Accept occurs when s_tvalid && s_tready.
  - Beat k of a group (k=0 first) writes ch0 to ch0 lane k and ch1 to ch1 lane k. Lane 0 holds the oldest sample.
- Group completion:
  - A group completes on the accepted beat where lane counter == P_SAMPLES-1, or where s_tlast=1.
  - Lanes not written stay 0: the assembly register is cleared on every transfer.
- Transfer to output:
  - If the output stage is empty, or is being drained this cycle (m_tvalid && m_tready), the completed group, including the completing beat's data, loads into the output stage on the same edge.
  - On that transfer: m_tvalid=1 next cycle, m_tlast = s_tlast of the completing beat, m_tcount = lanes filled. Lane counter and assembly register are cleared.
  - Otherwise pending is set to 1 and the group is held in the assembly register.
- s_tready:
  - Registered, equal to NOT pending.
  - No beats are accepted while pending=1.
- Pending release:
  - When pending=1 and the output drains, the pending group moves to the output stage on that edge: m_tvalid stays 1 with the new word.
  - pending clears on that edge, and s_tready=1 the following cycle.
- Output hold: while m_tvalid=1 && m_tready=0, m_tdata, m_tlast and m_tcount are held stable.
- Output drain: when m_tvalid && m_tready and nothing is transferring in, m_tvalid=0 next cycle. m_tdata keeps its last value.
- Latency and throughput:
  - Latency is 1 cycle from the accept of the completing beat to m_tvalid.
  - Throughput is one word per P_SAMPLES accepted beats, with no bubbles when m_tready is held at 1.
- Simultaneous events:
  - Completion and output drain on the same edge: the new word replaces the drained one, so m_tvalid stays 1.
  - s_tlast on beat 0: a 1-lane word, m_tcount=1.
  - s_tlast on beat P_SAMPLES-1: a normal full word with m_tlast=1.
- s_tvalid while s_tready=0: ignored. The input data need not be held by this block.
- Reset mid-operation: the partial group, pending group and output word are discarded. No word is emitted for them.
- Arithmetic: no arithmetic on samples; bits are passed through unchanged. The lane counter wraps P_SAMPLES-1 → 0 on completion.

Test Plan:
- Full-rate packing: m_tready=1; send 16 beats with ch0=0x0001..0x0010 and ch1=0x1001..0x1010.
  - Word 1: ch0 lanes 0..7 = 0x0001..0x0008, ch1 lanes = 0x1001..0x1008, m_tcount=8, m_tlast=0. m_tvalid rises 1 cycle after beat 8.
  - Word 2: same layout with 0x0009..0x0010 and 0x1009..0x1010.
  - No s_tready drop throughout.
- Early close: send 3 beats (0xAAAA/0xBBBB, each), s_tlast on beat 3.
  - m_tcount=3, m_tlast=1, lanes 0..2 = 0xAAAA/0xBBBB, lanes 3..7 = 0.
  - The next group starts at lane 0.
- Backpressure: m_tready=0; send 16 beats.
  - Word 1 is held stable and word 2 goes pending. s_tready=0 the cycle after beat 16.
  - Raise m_tready for 1 cycle: word 2 is presented the next cycle with m_tvalid still 1, and s_tready=1 one cycle later.
  - Beat 17 is not accepted while s_tready=0.
- Simultaneous complete and drain: m_tready=1 on the edge beat 8 of word 2 is accepted while word 1 is valid → m_tvalid stays high continuously; no word is lost or duplicated.
- Reset mid-group: after 5 beats, pulse nrst low asynchronously between edges.
  - All outputs are 0 immediately.
  - After release, 8 new beats produce one word containing only the new samples, with m_tcount=8.
- Single-beat tlast: one beat 0x7FFF/0x8000 with s_tlast=1 → m_tcount=1, m_tlast=1, ch0 lane0=0x7FFF, ch1 lane0=0x8000, all other lanes 0.
